// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory bus arbiter: request source tags and FSM states.
package mem_arbiter_pkg;

   typedef enum logic {SOURCE_IFETCH, SOURCE_DMEM} source_t;

   typedef enum logic [1:0] {
      STATE_IDLE,
      STATE_GRANT_IFETCH,
      STATE_GRANT_DMEM
   } state_t;

   // Pointer width for a FIFO of the given depth; a depth of 1 still needs one bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// System memory bus: request fields driven by the arbiter (master),
// accept handshake and in-order read returns driven by the memory (slave).
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32
) ();

   logic                      bus_enable;
   logic [ADDR_WIDTH-1:0]     bus_addr;
   logic                      bus_write;
   logic [DATA_WIDTH/8-1:0]   bus_byte_enable;
   logic [DATA_WIDTH-1:0]     bus_write_data;
   logic                      bus_ready;
   logic [DATA_WIDTH-1:0]     bus_read_data;
   logic                      bus_read_data_valid;

   modport master (
      output bus_enable, bus_addr, bus_write, bus_byte_enable, bus_write_data,
      input  bus_ready, bus_read_data, bus_read_data_valid
   );

   modport slave (
      input  bus_enable, bus_addr, bus_write, bus_byte_enable, bus_write_data,
      output bus_ready, bus_read_data, bus_read_data_valid
   );

endinterface

// File: rtl/mem_arbiter_tag_fifo.sv
// Source-tag FIFO: remembers which port issued each in-flight read so the
// in-order read returns can be steered back to it. Push and pop may coincide,
// including when full.
module mem_arbiter_tag_fifo
   import mem_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset_n,
   input  logic    push,
   input  source_t push_tag,
   input  logic    pop,
   output source_t head,
   output logic    empty,
   output logic    full
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   source_t          mem_reg [DEPTH];
   logic [DEPTH-1:0] wr_sel;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem_reg[rd_ptr_reg];

   // One-hot write select for the entry under the write pointer.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
   end

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Tag storage.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!reset_n) begin
            mem_reg[i] <= SOURCE_IFETCH;
         end else if (wr_sel[i]) begin
            mem_reg[i] <= push_tag;
         end
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the system memory bus between the instruction-fetch port
// and the data port. The winner's request is registered and held on the bus
// until accepted; read issue stalls while the source-tag FIFO is full.
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (round-robin on
// conflict); without it the data port always wins a conflict.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH      = 30,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,

   input  logic                    ifetch_req,
   input  logic [ADDR_WIDTH-1:0]   ifetch_addr,
   output logic                    ifetch_ready,
   output logic [DATA_WIDTH-1:0]   ifetch_read_data,
   output logic                    ifetch_read_valid,

   input  logic                    dmem_req,
   input  logic [ADDR_WIDTH-1:0]   dmem_addr,
   input  logic                    dmem_write,
   input  logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
   input  logic [DATA_WIDTH-1:0]   dmem_write_data,
   output logic                    dmem_ready,
   output logic [DATA_WIDTH-1:0]   dmem_read_data,
   output logic                    dmem_read_valid,

   mem_arbiter_if.master           bus,

   output logic                    error
);

   localparam int BE_W = DATA_WIDTH / 8;

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic                    write_reg;
   logic [BE_W-1:0]         byte_enable_reg;
   logic [DATA_WIDTH-1:0]   write_data_reg;
   logic                    error_reg;

   source_t                 winner;
   source_t                 grant_source;
   logic                    granting;
   logic                    issue_enable;
   logic                    accept;
   logic                    tag_push;
   logic                    tag_pop;
   source_t                 tag_head;
   logic                    tag_empty;
   logic                    tag_full;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   source_t                 last_grant_reg;
`endif

   // Pick the port to serve when leaving IDLE.
   always_comb begin
      winner = SOURCE_DMEM;
      if (ifetch_req && dmem_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         winner = (last_grant_reg == SOURCE_DMEM) ? SOURCE_IFETCH : SOURCE_DMEM;
`else
         winner = SOURCE_DMEM;
`endif
      end else if (ifetch_req) begin
         winner = SOURCE_IFETCH;
      end
   end

   // Issue stalls on a read only while the (registered) tag count is full.
   assign granting     = (state_reg != STATE_IDLE);
   assign grant_source = (state_reg == STATE_GRANT_IFETCH) ? SOURCE_IFETCH : SOURCE_DMEM;
   assign issue_enable = granting && (write_reg || !tag_full);
   assign accept       = issue_enable && bus.bus_ready;
   assign tag_push     = accept && !write_reg;
   assign tag_pop      = bus.bus_read_data_valid;

   assign ifetch_ready = accept && (state_reg == STATE_GRANT_IFETCH);
   assign dmem_ready   = accept && (state_reg == STATE_GRANT_DMEM);

   assign bus.bus_enable      = issue_enable;
   assign bus.bus_addr        = addr_reg;
   assign bus.bus_write       = write_reg;
   assign bus.bus_byte_enable = byte_enable_reg;
   assign bus.bus_write_data  = write_data_reg;

   // Read returns are steered by the FIFO head; data is broadcast to both ports.
   assign ifetch_read_data  = bus.bus_read_data;
   assign dmem_read_data    = bus.bus_read_data;
   assign ifetch_read_valid = tag_pop && !tag_empty && (tag_head == SOURCE_IFETCH);
   assign dmem_read_valid   = tag_pop && !tag_empty && (tag_head == SOURCE_DMEM);
   assign error             = error_reg;

   mem_arbiter_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (tag_push),
      .push_tag (grant_source),
      .pop      (tag_pop),
      .head     (tag_head),
      .empty    (tag_empty),
      .full     (tag_full)
   );

   // Arbitration FSM: latch the winner in IDLE, hold it until the bus accepts.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= STATE_IDLE;
         addr_reg        <= '0;
         write_reg       <= 1'b0;
         byte_enable_reg <= '0;
         write_data_reg  <= '0;
      end else begin
         case (state_reg)
            STATE_IDLE: begin
               if (ifetch_req || dmem_req) begin
                  if (winner == SOURCE_IFETCH) begin
                     addr_reg        <= ifetch_addr;
                     write_reg       <= 1'b0;
                     byte_enable_reg <= '0;
                     write_data_reg  <= '0;
                     state_reg       <= STATE_GRANT_IFETCH;
                  end else begin
                     addr_reg        <= dmem_addr;
                     write_reg       <= dmem_write;
                     byte_enable_reg <= dmem_byte_enable;
                     write_data_reg  <= dmem_write_data;
                     state_reg       <= STATE_GRANT_DMEM;
                  end
               end
            end
            STATE_GRANT_IFETCH, STATE_GRANT_DMEM: begin
               if (accept) state_reg <= STATE_IDLE;
            end
            default: state_reg <= STATE_IDLE;
         endcase
      end
   end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   // Remember the last port granted so the other one wins the next conflict.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant_reg <= SOURCE_DMEM;
      end else if ((state_reg == STATE_IDLE) && (ifetch_req || dmem_req)) begin
         last_grant_reg <= winner;
      end
   end
`endif

   // Sticky error: a read return arrived with nothing outstanding.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         error_reg <= 1'b0;
      end else if (tag_pop && tag_empty) begin
         error_reg <= 1'b1;
      end
   end

endmodule
